// File: rtl/lsu_data_memory.sv
// Load/store data memory: byte-lane stores, sign/zero-extended loads, fault detection,
// fixed-latency pipelined responses, and an optional zeroing sweep after reset.
module lsu_data_memory #(
  parameter int MEM_DEPTH      = 1024,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        init_done
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       fault;
    logic       load;
    logic [2:0] funct3;
    logic [1:0] offset;
  } ctrl_t;

  state_t           state;
  logic [IDX_W-1:0] sweep_ptr;
  logic [31:0]      mem [MEM_DEPTH];

  ctrl_t            pipe_ctrl [READ_LATENCY];
  logic [31:0]      pipe_word [READ_LATENCY];

  logic             accept;
  logic             size_ok;
  logic             align_ok;
  logic             range_ok;
  logic             fault;
  logic             do_store;
  logic [IDX_W-1:0] word_idx;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_lanes;

  ctrl_t            out_ctrl;
  logic [31:0]      out_word;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [31:0]      ext_data;

  assign req_ready = (state == READY);
  assign init_done = req_ready;
  assign accept    = req_valid && req_ready && rst_n;
  assign word_idx  = req_addr[IDX_W+1:2];
  assign range_ok  = req_addr[31:2] < 30'(MEM_DEPTH);
  assign fault     = !(size_ok && align_ok && range_ok);
  assign do_store  = accept && req_we && !fault;

  // Request decode: legality, alignment, lane enables and lane-replicated store data.
  always_comb begin
    size_ok     = 1'b0;
    align_ok    = 1'b1;
    byte_en     = 4'b0000;
    wdata_lanes = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        size_ok     = req_we ? !req_funct3[2] : 1'b1;
        byte_en     = 4'b0001 << req_addr[1:0];
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        size_ok     = req_we ? !req_funct3[2] : 1'b1;
        align_ok    = !req_addr[0];
        byte_en     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        size_ok     = !req_funct3[2];
        align_ok    = (req_addr[1:0] == 2'b00);
        byte_en     = 4'b1111;
      end
      default: begin
        size_ok     = 1'b0;
      end
    endcase
  end

  // Sweep controller; without the clear option it leaves INIT on the first released edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_ptr <= '0;
    end else if (state == INIT) begin
      if (!CLEAR_ON_RESET || sweep_ptr == IDX_W'(MEM_DEPTH - 1)) begin
        state <= READY;
      end else begin
        sweep_ptr <= sweep_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == INIT && CLEAR_ON_RESET) begin
      mem[sweep_ptr] <= '0;
    end else if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
      end
    end
  end

  // Raw read words travel unreset; the control pipeline below decides whether they are used.
  always_ff @(posedge clk) begin
    if (accept) begin
      pipe_word[0] <= mem[word_idx];
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_word[i] <= pipe_word[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_ctrl[i] <= '0;
      end
    end else begin
      pipe_ctrl[0].valid  <= accept;
      pipe_ctrl[0].fault  <= fault;
      pipe_ctrl[0].load   <= !req_we;
      pipe_ctrl[0].funct3 <= req_funct3;
      pipe_ctrl[0].offset <= req_addr[1:0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_ctrl[i] <= pipe_ctrl[i-1];
      end
    end
  end

  always_comb begin
    out_ctrl = pipe_ctrl[READ_LATENCY-1];
    out_word = pipe_word[READ_LATENCY-1];
    case (out_ctrl.offset)
      2'd0:    sel_byte = out_word[7:0];
      2'd1:    sel_byte = out_word[15:8];
      2'd2:    sel_byte = out_word[23:16];
      default: sel_byte = out_word[31:24];
    endcase
    sel_half = out_ctrl.offset[1] ? out_word[31:16] : out_word[15:0];
    case (out_ctrl.funct3)
      3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ext_data = {24'd0, sel_byte};
      3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  ext_data = {16'd0, sel_half};
      default: ext_data = out_word;
    endcase
  end

  assign rsp_valid = out_ctrl.valid;
  assign rsp_fault = out_ctrl.valid && out_ctrl.fault;
  assign rsp_rdata = (out_ctrl.valid && out_ctrl.load && !out_ctrl.fault) ? ext_data : 32'd0;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed bench for lsu_data_memory (16 words, 3-cycle latency, clear on reset):
// vector table for single transactions plus hand sequences for pipelining and mid-traffic reset.
module tb_lsu_data_memory;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  lsu_data_memory #(
    .MEM_DEPTH(DEPTH),
    .READ_LATENCY(LAT),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic void add_vec(input string name, input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_rdata, input logic exp_fault);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_fault = exp_fault;
    vecs.push_back(v);
  endfunction

  // One request, then wait (bounded) for its response and check data, fault, latency, pulse width.
  task automatic applyStimulus(input vec_t v);
    int lat;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({v.name, " latency"}, 32'(lat), 32'(LAT));
    checkOutput({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
    checkOutput({v.name, " fault"}, {31'd0, rsp_fault}, {31'd0, v.exp_fault});
    @(negedge clk);
    checkOutput({v.name, " single pulse"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic wait_ready(input string name, output int edges, output int stray_rsp);
    edges = 0;
    stray_rsp = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (rsp_valid) stray_rsp++;
      if (req_ready) break;
    end
    checkOutput({name, " edges to ready"}, 32'(edges), 32'(DEPTH));
    checkOutput({name, " init_done"}, {31'd0, init_done}, 32'd1);
  endtask

  initial begin
    int edges;
    int stray;
    int rsp_cycle [4];
    logic [31:0] rsp_data [4];
    int nrsp;
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp [4];

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("reset init_done", {31'd0, init_done}, 32'd0);
    checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset rsp_fault", {31'd0, rsp_fault}, 32'd0);
    rst_n = 1'b1;
    wait_ready("sweep", edges, stray);
    checkOutput("sweep stray rsp", 32'(stray), 32'd0);

    add_vec("LW 0x00 cleared",   1'b0, 3'b010, 32'h00, 32'h0, 32'h0000_0000, 1'b0);
    add_vec("LW 0x3C cleared",   1'b0, 3'b010, 32'h3C, 32'h0, 32'h0000_0000, 1'b0);
    add_vec("SW 0x10",           1'b1, 3'b010, 32'h10, 32'h8000_00F0, 32'h0, 1'b0);
    add_vec("LB 0x10",           1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFF0, 1'b0);
    add_vec("LBU 0x10",          1'b0, 3'b100, 32'h10, 32'h0, 32'h0000_00F0, 1'b0);
    add_vec("LH 0x12",           1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8000, 1'b0);
    add_vec("LHU 0x12",          1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8000, 1'b0);
    add_vec("LW 0x10",           1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_00F0, 1'b0);
    add_vec("SW 0x20",           1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
    add_vec("SB 0x22",           1'b1, 3'b000, 32'h22, 32'h1234_56AA, 32'h0, 1'b0);
    add_vec("SH 0x20",           1'b1, 3'b001, 32'h20, 32'hFFFF_BEEF, 32'h0, 1'b0);
    add_vec("LW 0x20 merged",    1'b0, 3'b010, 32'h20, 32'h0, 32'h11AA_BEEF, 1'b0);
    add_vec("LB 0x23",           1'b0, 3'b000, 32'h23, 32'h0, 32'h0000_0011, 1'b0);
    add_vec("LB 0x22",           1'b0, 3'b000, 32'h22, 32'h0, 32'hFFFF_FFAA, 1'b0);
    add_vec("LBU 0x22",          1'b0, 3'b100, 32'h22, 32'h0, 32'h0000_00AA, 1'b0);
    add_vec("SW 0x30",           1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0);
    add_vec("SH 0x31 misalign",  1'b1, 3'b001, 32'h31, 32'h0000_1234, 32'h0, 1'b1);
    add_vec("LW 0x22 misalign",  1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1);
    add_vec("LW range",          1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1);
    add_vec("load f3=011",       1'b0, 3'b011, 32'h30, 32'h0, 32'h0, 1'b1);
    add_vec("load f3=110",       1'b0, 3'b110, 32'h30, 32'h0, 32'h0, 1'b1);
    add_vec("store f3=100",      1'b1, 3'b100, 32'h30, 32'h0000_0000, 32'h0, 1'b1);
    add_vec("store f3=011",      1'b1, 3'b011, 32'h30, 32'h0000_0000, 32'h0, 1'b1);
    add_vec("LHU 0x33 misalign", 1'b0, 3'b101, 32'h33, 32'h0, 32'h0, 1'b1);
    add_vec("SB range",          1'b1, 3'b000, 32'h44, 32'h0000_0055, 32'h0, 1'b1);
    add_vec("LW 0x04 untouched", 1'b0, 3'b010, 32'h04, 32'h0, 32'h0000_0000, 1'b0);
    add_vec("LW 0x30 unchanged", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0);
    add_vec("LH 0x32",           1'b0, 3'b001, 32'h32, 32'h0, 32'hFFFF_CAFE, 1'b0);
    add_vec("LHU 0x30",          1'b0, 3'b101, 32'h30, 32'h0, 32'h0000_F00D, 1'b0);
    add_vec("LB 0x31",           1'b0, 3'b000, 32'h31, 32'h0, 32'hFFFF_FFF0, 1'b0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Four back-to-back loads: responses must be consecutive, LAT cycles behind, in order.
    b2b_addr[0] = 32'h10; b2b_exp[0] = 32'h8000_00F0;
    b2b_addr[1] = 32'h20; b2b_exp[1] = 32'h11AA_BEEF;
    b2b_addr[2] = 32'h30; b2b_exp[2] = 32'hCAFE_F00D;
    b2b_addr[3] = 32'h00; b2b_exp[3] = 32'h0000_0000;
    nrsp = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (rsp_valid && nrsp < 4) begin
        rsp_cycle[nrsp] = t;
        rsp_data[nrsp]  = rsp_rdata;
        nrsp++;
      end
      if (t < 4) begin
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = b2b_addr[t]; req_wdata = '0;
      end else begin
        req_valid = 1'b0;
      end
    end
    checkOutput("b2b response count", 32'(nrsp), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < nrsp) begin
        checkOutput($sformatf("b2b rsp%0d cycle", k), 32'(rsp_cycle[k]), 32'(LAT + k));
        checkOutput($sformatf("b2b rsp%0d data", k), rsp_data[k], b2b_exp[k]);
      end
    end

    // Reset with two loads in flight: both responses dropped, sweep reruns.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(negedge clk);
    req_addr = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("midreset req_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    wait_ready("resweep", edges, stray);
    checkOutput("resweep stray rsp", 32'(stray), 32'd0);
    applyStimulus('{name: "LW 0x10 after resweep", we: 1'b0, f3: 3'b010, addr: 32'h10,
                    wdata: 32'h0, exp_rdata: 32'h0, exp_fault: 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
